// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures the decoded control bundle and operands,
// supports stall (hold), flush (bubble injection) and tracks bubbles inserted.
module id_ex_pipeline_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               le,
    input  logic               flush,
    input  logic               ID_valid,
    input  logic [3:0]         ID_opcode,
    input  logic               ID_AM,
    input  logic               ID_S_enable,
    input  logic               ID_load_instr,
    input  logic               ID_RF_enable,
    input  logic               ID_Size_enable,
    input  logic               ID_RW_enable,
    input  logic               ID_Enable_signal,
    input  logic               ID_BL_instr,
    input  logic               ID_B_instr,
    input  logic [3:0]         ID_cond,
    input  logic [RADDR_W-1:0] ID_Rd,
    input  logic [DATA_W-1:0]  ID_PA,
    input  logic [DATA_W-1:0]  ID_PB,
    input  logic [DATA_W-1:0]  ID_PD,
    input  logic [11:0]        ID_shift_imm,
    input  logic [DATA_W-1:0]  ID_next_pc,
    output logic [3:0]         EX_opcode,
    output logic               EX_AM,
    output logic               EX_S_enable,
    output logic               EX_load_instr,
    output logic               EX_RF_enable,
    output logic               EX_Size_enable,
    output logic               EX_RW_enable,
    output logic               EX_Enable_signal,
    output logic               EX_BL_instr,
    output logic               EX_B_instr,
    output logic [3:0]         EX_cond,
    output logic [RADDR_W-1:0] EX_Rd,
    output logic [DATA_W-1:0]  EX_PA,
    output logic [DATA_W-1:0]  EX_PB,
    output logic [DATA_W-1:0]  EX_PD,
    output logic [11:0]        EX_shift_imm,
    output logic [DATA_W-1:0]  EX_next_pc,
    output logic               EX_valid,
    output logic               EX_load_hazard,
    output logic [7:0]         bubble_count
);

    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [7:0] COUNT_MAX = 8'hFF;

    typedef struct packed {
        logic [3:0]         opcode;
        logic               am;
        logic               sEnable;
        logic               loadInstr;
        logic               rfEnable;
        logic               sizeEnable;
        logic               rwEnable;
        logic               enableSignal;
        logic               blInstr;
        logic               bInstr;
        logic [3:0]         cond;
        logic [RADDR_W-1:0] rd;
        logic [DATA_W-1:0]  pa;
        logic [DATA_W-1:0]  pb;
        logic [DATA_W-1:0]  pd;
        logic [11:0]        shiftImm;
        logic [DATA_W-1:0]  nextPc;
    } exBundle_t;

    exBundle_t  idBundle;
    exBundle_t  bundle_d, bundle_q;
    logic       valid_d, valid_q;
    logic [7:0] bubbleCount_d, bubbleCount_q;
    logic       bubbleEvent;

    always_comb begin
        idBundle.opcode       = ID_opcode;
        idBundle.am           = ID_AM;
        idBundle.sEnable      = ID_S_enable;
        idBundle.loadInstr    = ID_load_instr;
        idBundle.rfEnable     = ID_RF_enable;
        idBundle.sizeEnable   = ID_Size_enable;
        idBundle.rwEnable     = ID_RW_enable;
        idBundle.enableSignal = ID_Enable_signal;
        idBundle.blInstr      = ID_BL_instr;
        idBundle.bInstr       = ID_B_instr;
        idBundle.cond         = ID_cond;
        idBundle.rd           = ID_Rd;
        idBundle.pa           = ID_PA;
        idBundle.pb           = ID_PB;
        idBundle.pd           = ID_PD;
        idBundle.shiftImm     = ID_shift_imm;
        idBundle.nextPc       = ID_next_pc;
    end

    // A bubble is either a flush or a non-real instruction entering EX.
    assign bubbleEvent = flush | (le & ~ID_valid);

    always_comb begin
        bundle_d      = bundle_q;
        valid_d       = valid_q;
        bubbleCount_d = bubbleCount_q;
        if (flush) begin
            bundle_d      = '0;
            bundle_d.cond = COND_AL;
            valid_d       = 1'b0;
        end else if (le) begin
            bundle_d = idBundle;
            valid_d  = ID_valid;
        end
        if (bubbleEvent && (bubbleCount_q != COUNT_MAX)) begin
            bubbleCount_d = bubbleCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bundle_q      <= '0;
            valid_q       <= 1'b0;
            bubbleCount_q <= '0;
        end else begin
            bundle_q      <= bundle_d;
            valid_q       <= valid_d;
            bubbleCount_q <= bubbleCount_d;
        end
    end

    assign EX_opcode        = bundle_q.opcode;
    assign EX_AM            = bundle_q.am;
    assign EX_S_enable      = bundle_q.sEnable;
    assign EX_load_instr    = bundle_q.loadInstr;
    assign EX_RF_enable     = bundle_q.rfEnable;
    assign EX_Size_enable   = bundle_q.sizeEnable;
    assign EX_RW_enable     = bundle_q.rwEnable;
    assign EX_Enable_signal = bundle_q.enableSignal;
    assign EX_BL_instr      = bundle_q.blInstr;
    assign EX_B_instr       = bundle_q.bInstr;
    assign EX_cond          = bundle_q.cond;
    assign EX_Rd            = bundle_q.rd;
    assign EX_PA            = bundle_q.pa;
    assign EX_PB            = bundle_q.pb;
    assign EX_PD            = bundle_q.pd;
    assign EX_shift_imm     = bundle_q.shiftImm;
    assign EX_next_pc       = bundle_q.nextPc;
    assign EX_valid         = valid_q;
    assign bubble_count     = bubbleCount_q;

    // Load-use detection for the hazard unit, purely from registered state.
    assign EX_load_hazard = valid_q & bundle_q.loadInstr & bundle_q.rfEnable;

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
Pipeline register between Decode (ID) and Execute (EX) of the 5-stage ARM-subset core. Captures the control bundle from the control-unit NOP mux, plus register-file operands, destination register, shifter operand and condition field. Supports stall (hold), flush (inject bubble) and a valid tag. Publishes EX-stage destination info to the hazard/forwarding unit.

Parameters:
DATA_W, 32, width of register operands and PC
RADDR_W, 4, register-file address width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
le  input  1  load enable; 0 = stall, hold all contents
flush  input  1  branch-taken/exception flush; load a bubble
ID_valid  input  1  instruction in ID is real (not a NOP slot)
ID_opcode  input  4  ALU opcode from CU mux
ID_AM  input  1  addressing-mode select
ID_S_enable  input  1  update flags
ID_load_instr  input  1  load instruction
ID_RF_enable  input  1  register-file write enable
ID_Size_enable  input  1  byte/word access size
ID_RW_enable  input  1  memory read/write
ID_Enable_signal  input  1  memory enable
ID_BL_instr  input  1  branch-and-link
ID_B_instr  input  1  branch
ID_cond  input  4  instruction condition field
ID_Rd  input  RADDR_W  destination register
ID_PA, ID_PB, ID_PD  input  DATA_W  operand values from RF/forwarding muxes
ID_shift_imm  input  12  shifter operand field
ID_next_pc  input  DATA_W  PC+4 for BL link value
EX_* (opcode, AM, S_enable, load_instr, RF_enable, Size_enable, RW_enable, Enable_signal, BL_instr, B_instr, cond, Rd, PA, PB, PD, shift_imm, next_pc)  output  matching widths  registered copies
EX_valid  output  1  EX slot holds a real instruction
EX_load_hazard  output  1  EX_valid & EX_load_instr & EX_RF_enable (load-use detect)
bubble_count  output  8  saturating count of bubbles inserted since reset

Behaviour:
- Reset (async, reset=1): every EX_* output 0, EX_valid 0, EX_load_hazard 0, bubble_count 0; held while reset asserted; takes effect mid-cycle without clock.
- All other updates on clk rising edge, priority flush > stall > load.
- flush=1: all control outputs (opcode, AM, S_enable, load_instr, RF_enable, Size_enable, RW_enable, Enable_signal, BL_instr, B_instr) -> 0, cond -> 4'b1110 (AL), EX_valid -> 0; datapath fields (Rd, PA, PB, PD, shift_imm, next_pc) -> 0. Applies regardless of le.
- flush=0, le=0: hold every output unchanged, including EX_valid.
- flush=0, le=1: capture all ID_* inputs; EX_valid <= ID_valid.
- Latency: one cycle ID -> EX.
- EX_load_hazard: combinational from registered outputs, no extra latency.
- bubble_count: +1 on each edge where (flush=1) or (le=1 and ID_valid=0); saturates at 255, never wraps; held when le=0 and flush=0.
- Control outputs with ID_valid=0 are captured as presented (CU mux already zeroes them); EX_valid is the authority for downstream write-back and memory enables.
- No combinational path from any ID_* input to any EX_* output.

Test Plan:
- Reset: assert reset mid-cycle with EX_RF_enable=1, EX_Rd=5 -> all outputs 0 immediately, bubble_count=0.
- Normal load: le=1, ID_opcode=4'b0100, ID_Rd=3, ID_PA=32'h0000_00AA, ID_valid=1 -> next edge EX_opcode=4'b0100, EX_Rd=3, EX_PA=32'hAA, EX_valid=1.
- Stall: load LDR R2 (ID_load_instr=1, ID_RF_enable=1, ID_Rd=2), then le=0 for 3 cycles with changing ID inputs -> EX outputs frozen, EX_load_hazard=1 throughout.
- Flush vs stall: le=0, flush=1 while EX holds valid ADD -> next edge EX_valid=0, all control 0, EX_cond=4'b1110, bubble_count +1.
- Bubble injection: le=1, ID_valid=0 (CU mux S=1) for 2 cycles -> EX_valid=0, bubble_count increments by 2.
- Saturation: 260 consecutive flushes -> bubble_count=255, stays 255.
